// File: rtl/stream_pkg.sv
// Shared constants and types for FIFO-to-stream adapters.
// Occupancy of the small skid buffer is carried as occ_t.
package stream_pkg;

  localparam int OCC_W     = 2;
  localparam int BUF_DEPTH = 2;

  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_EMPTY = occ_t'(0);
  localparam occ_t OCC_ONE   = occ_t'(1);
  localparam occ_t OCC_FULL  = occ_t'(BUF_DEPTH);

endpackage

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO pop interface into a registered valid/ready stream.
// A head/tail buffer keeps full throughput without a ready_i -> fifo_pop_o path.
module fifo_stream_drain
  import stream_pkg::*;
#(
  parameter type dtype     = logic [31:0],
  parameter int  CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  dtype                 fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output dtype                 data_o,
  output occ_t                 occ_o,
  output logic [CNT_WIDTH-1:0] beats_o,
  output logic                 idle_o
);

  dtype                 head_q, head_d;
  dtype                 tail_q, tail_d;
  occ_t                 occ_q, occ_d;
  logic [CNT_WIDTH-1:0] beats_q, beats_d;
  logic                 pop;
  logic                 hs;

  // Pop only depends on local occupancy, never on ready_i.
  assign pop        = !fifo_empty_i && !flush_i && !rst_i && (occ_q < OCC_FULL);
  assign hs         = valid_o && ready_i;

  assign fifo_pop_o = pop;
  assign valid_o    = (occ_q != OCC_EMPTY);
  assign data_o     = head_q;
  assign occ_o      = occ_q;
  assign beats_o    = beats_q;
  assign idle_o     = (occ_q == OCC_EMPTY) && fifo_empty_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    beats_d = beats_q + CNT_WIDTH'(hs);
    case (occ_q)
      OCC_EMPTY: begin
        if (pop) begin
          head_d = fifo_data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (pop && !hs) begin
          tail_d = fifo_data_i;
          occ_d  = OCC_FULL;
        end else if (pop && hs) begin
          head_d = fifo_data_i;
        end else if (hs) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (hs) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= OCC_EMPTY;
      beats_q <= '0;
    end else if (flush_i) begin
      // Flush drops buffered entries and any same-cycle handshake; payload regs keep stale data.
      occ_q   <= OCC_EMPTY;
      beats_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      beats_q <= beats_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) occ_q != 2'b11);

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Randomised bench: a queue-based FIFO and buffer model drive and check two drain instances.
// The narrow instance shares all stimulus and checks counter wrap at 4 bits.
module tb_fifo_stream_drain;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, fifo_empty, ready;
  logic [31:0] fifo_data;
  logic        pop, valid, idle;
  logic [31:0] data;
  logic [1:0]  occ;
  logic [15:0] beats;
  logic        pop_w, valid_w, idle_w;
  logic [31:0] data_w;
  logic [1:0]  occ_w;
  logic [3:0]  beats_w;

  fifo_stream_drain #(.dtype(logic [31:0]), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_pop_o(pop), .valid_o(valid), .ready_i(ready),
    .data_o(data), .occ_o(occ), .beats_o(beats), .idle_o(idle)
  );

  fifo_stream_drain #(.dtype(logic [31:0]), .CNT_WIDTH(4)) dut_w (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_pop_o(pop_w), .valid_o(valid_w), .ready_i(ready),
    .data_o(data_w), .occ_o(occ_w), .beats_o(beats_w), .idle_o(idle_w)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] upq[$];
  logic [31:0] bufq[$];
  logic [31:0] sbq[$];
  logic [15:0] beats_m;
  bit          sb_en;
  int          sb_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: present FIFO head, check outputs against the model, advance the model at the edge.
  task automatic cycle();
    logic exp_pop, hs_m, pop_s;
    fifo_empty = (upq.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : upq[0];
    #1;
    exp_pop = !fifo_empty && !flush && !rst && (bufq.size() < 2);
    check_eq("pop", pop, exp_pop);
    check_eq("pop_w", pop_w, exp_pop);
    check_eq("valid", valid, bufq.size() != 0);
    check_eq("valid_w", valid_w, bufq.size() != 0);
    check_eq("occ", occ, bufq.size());
    check_eq("occ_w", occ_w, bufq.size());
    if (bufq.size() != 0) begin
      check_eq("data", data, bufq[0]);
      check_eq("data_w", data_w, bufq[0]);
    end
    check_eq("beats", beats, beats_m);
    check_eq("beats_w", beats_w, beats_m[3:0]);
    check_eq("idle", idle, (bufq.size() == 0) && fifo_empty);
    check_eq("idle_w", idle_w, (bufq.size() == 0) && fifo_empty);
    if (sb_en && valid && ready && !flush && !rst) begin
      if (sb_cnt < sbq.size()) check_eq("sb_order", data, sbq[sb_cnt]);
      else check_eq("sb_extra", sb_cnt, sbq.size());
      sb_cnt++;
    end
    pop_s = pop;
    @(posedge clk);
    if (rst || flush) begin
      bufq.delete();
      beats_m = '0;
    end else begin
      hs_m = (bufq.size() != 0) && ready;
      if (hs_m) begin
        void'(bufq.pop_front());
        beats_m = beats_m + 16'd1;
      end
      if (exp_pop) bufq.push_back(upq[0]);
    end
    if (pop_s && upq.size() != 0) void'(upq.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int pushed;
    int guard;
    rst = 1'b1; flush = 1'b0; ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    beats_m = '0; sb_en = 1'b0; sb_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_data", data, 32'h0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_pop", pop, 1'b0);
    rst = 1'b0;

    // Reset then stream three entries
    ready = 1'b1;
    upq.push_back(32'h11); upq.push_back(32'h22); upq.push_back(32'h33);
    run(6);
    check_eq("p1_beats", beats, 32'd3);
    check_eq("p1_idle", idle, 1'b1);

    // Backpressure: only two pops, head stable
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) upq.push_back(32'hA0 + i);
    run(5);
    #1;
    check_eq("bp_occ", occ, 32'd2);
    check_eq("bp_pop", pop, 1'b0);
    check_eq("bp_data", data, 32'hA1);
    ready = 1'b1;
    run(6);
    check_eq("bp_beats", beats, 32'd7);

    // Flush with occ=2 and beats=5
    flush = 1'b1; run(1); flush = 1'b0;
    for (int i = 0; i < 5; i++) upq.push_back(32'hB0 + i);
    run(7);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) upq.push_back(32'hC0 + i);
    run(3);
    #1;
    check_eq("fl_pre_occ", occ, 32'd2);
    check_eq("fl_pre_beats", beats, 32'd5);
    flush = 1'b1; run(1); flush = 1'b0;
    #1;
    check_eq("fl_occ", occ, 32'd0);
    check_eq("fl_valid", valid, 1'b0);
    check_eq("fl_beats", beats, 32'd0);
    ready = 1'b1;
    run(4);

    // Synchronous reset mid-stream
    ready = 1'b0;
    for (int i = 0; i < 3; i++) upq.push_back(32'hD0 + i);
    run(1);
    rst = 1'b1; run(1); rst = 1'b0;
    #1;
    check_eq("mr_valid", valid, 1'b0);
    check_eq("mr_data", data, 32'h0);
    check_eq("mr_occ", occ, 32'd0);
    check_eq("mr_pop", pop, 1'b1);
    ready = 1'b1;
    run(5);

    // Counter wrap on the 4-bit instance
    flush = 1'b1; run(1); flush = 1'b0;
    for (int i = 0; i < 17; i++) upq.push_back(32'hE000 + i);
    run(20);
    check_eq("wrap_w", beats_w, 32'd1);
    check_eq("wrap_16", beats, 32'd17);

    // Random ready, random arrival, 1000 entries
    flush = 1'b1; run(1); flush = 1'b0;
    sb_en = 1'b1; sb_cnt = 0; pushed = 0; guard = 0;
    while ((sb_cnt < 1000) && (guard < 20000)) begin
      if ((pushed < 1000) && ($urandom_range(0, 3) != 0)) begin
        logic [31:0] v;
        v = $urandom;
        upq.push_back(v);
        sbq.push_back(v);
        pushed++;
      end
      ready = $urandom_range(0, 1);
      cycle();
      guard++;
    end
    sb_en = 1'b0;
    ready = 1'b0;
    #1;
    check_eq("rnd_count", sb_cnt, 32'd1000);
    check_eq("rnd_beats", beats, 32'd1000);
    check_eq("rnd_beats_w", beats_w, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
